// File: rtl/fir_mac_sequencer.sv
`timescale 1ns/1ps
// fir_mac_sequencer: control FSM for a single-MAC FIR datapath (zero-fill, tap walk, drain, latch, output).
// Define FIR_SYMMETRIC_EN to walk only NTAPS/2 taps with a pre-adder on two delay-line read ports.
module fir_mac_sequencer #(
  parameter int NTAPS   = 16,
  parameter int AW      = 4,
  parameter int MAC_LAT = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic          SMP_WE,
  output logic          SMP_ZERO,
  output logic [AW-1:0] SMP_WADDR,
  output logic [AW-1:0] SMP_RADDR,
  output logic [AW-1:0] SMP_RADDR2,
  output logic [AW-1:0] COEF_ADDR,
  output logic          MAC_EN,
  output logic          MAC_CLR,
  output logic          PRE_ADD,
  output logic          ACC_LATCH,
  output logic          OUT_VALID,
  input  logic          OUT_READY
);

  localparam int LW = $clog2(MAC_LAT + 1);
  localparam int CW = (AW > LW) ? AW : LW;

`ifdef FIR_SYMMETRIC_EN
  localparam int MAC_STEPS = NTAPS / 2;
`else
  localparam int MAC_STEPS = NTAPS;
`endif

  localparam logic [CW-1:0] INIT_LAST  = CW'(NTAPS - 1);
  localparam logic [CW-1:0] MAC_LAST   = CW'(MAC_STEPS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(MAC_LAT - 1);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_newest;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic [AW-1:0] w_k;

  // A sample is taken in IDLE, or in OUT when the result is consumed in the same cycle.
  assign w_accept = IN_VALID & ((r_state == S_IDLE) | ((r_state == S_OUT) & OUT_READY));
  assign w_k      = r_cnt[AW-1:0];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        if (r_cnt == INIT_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_MAC;
          w_cnt_nxt   = '0;
        end
      end
      S_MAC: begin
        if (r_cnt == MAC_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = S_LATCH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LATCH: begin
        w_state_nxt = S_OUT;
        w_cnt_nxt   = '0;
      end
      S_OUT: begin
        if (w_accept) begin
          w_state_nxt = S_MAC;
          w_cnt_nxt   = '0;
        end else if (OUT_READY) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_wptr   <= '0;
      r_newest <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_newest <= r_wptr;
        r_wptr   <= r_wptr + 1'b1;
      end
    end
  end

  // Outputs decode straight from state; RST gates them so they drop within the cycle it rises.
  always_comb begin
    IN_READY   = 1'b0;
    SMP_WE     = 1'b0;
    SMP_ZERO   = 1'b0;
    SMP_WADDR  = '0;
    SMP_RADDR  = '0;
    SMP_RADDR2 = '0;
    COEF_ADDR  = '0;
    MAC_EN     = 1'b0;
    MAC_CLR    = 1'b0;
    PRE_ADD    = 1'b0;
    ACC_LATCH  = 1'b0;
    OUT_VALID  = 1'b0;
    if (!RST) begin
      case (r_state)
        S_INIT: begin
          SMP_WE    = 1'b1;
          SMP_ZERO  = 1'b1;
          SMP_WADDR = w_k;
        end
        S_IDLE: begin
          IN_READY = 1'b1;
          if (w_accept) begin
            SMP_WE    = 1'b1;
            SMP_WADDR = r_wptr;
          end
        end
        S_MAC: begin
          MAC_EN    = 1'b1;
          MAC_CLR   = (r_cnt == '0);
          COEF_ADDR = w_k;
          SMP_RADDR = r_newest - w_k;
`ifdef FIR_SYMMETRIC_EN
          // Mirror tap NTAPS-1-k: newest-(NTAPS-1-k) == newest+1+k modulo NTAPS.
          PRE_ADD    = 1'b1;
          SMP_RADDR2 = r_newest + 1'b1 + w_k;
`endif
        end
        S_LATCH: begin
          ACC_LATCH = 1'b1;
        end
        S_OUT: begin
          OUT_VALID = 1'b1;
          IN_READY  = OUT_READY;
          if (w_accept) begin
            SMP_WE    = 1'b1;
            SMP_WADDR = r_wptr;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for fir_mac_sequencer: a behavioural delay line + MAC driven by the DUT controls,
// checked against a reference FIR through a scoreboard, plus per-scenario timing checks.
module tb_fir_mac_sequencer;

  localparam int NTAPS   = 16;
  localparam int AW      = 4;
  localparam int MAC_LAT = 2;
`ifdef FIR_SYMMETRIC_EN
  localparam int STEPS = NTAPS / 2;
  localparam bit SYM   = 1'b1;
`else
  localparam int STEPS = NTAPS;
  localparam bit SYM   = 1'b0;
`endif
  localparam int LAT_OUT = STEPS + MAC_LAT + 2;
  localparam int OW      = 4 * AW + 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          OUT_READY = 1'b0;
  logic          IN_READY, SMP_WE, SMP_ZERO, MAC_EN, MAC_CLR, PRE_ADD, ACC_LATCH, OUT_VALID;
  logic [AW-1:0] SMP_WADDR, SMP_RADDR, SMP_RADDR2, COEF_ADDR;
  logic [7:0]    in_data = 8'd0;

  always #5 CLK = ~CLK;

  fir_mac_sequencer #(.NTAPS(NTAPS), .AW(AW), .MAC_LAT(MAC_LAT)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SMP_WE(SMP_WE), .SMP_ZERO(SMP_ZERO), .SMP_WADDR(SMP_WADDR),
    .SMP_RADDR(SMP_RADDR), .SMP_RADDR2(SMP_RADDR2), .COEF_ADDR(COEF_ADDR),
    .MAC_EN(MAC_EN), .MAC_CLR(MAC_CLR), .PRE_ADD(PRE_ADD), .ACC_LATCH(ACC_LATCH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  logic [OW-1:0] all_outs;
  assign all_outs = {IN_READY, SMP_WE, SMP_ZERO, MAC_EN, MAC_CLR, PRE_ADD, ACC_LATCH, OUT_VALID,
                     SMP_WADDR, SMP_RADDR, SMP_RADDR2, COEF_ADDR};

  int errors = 0;
  int checks = 0;

  int            sb[$];
  int            hist[NTAPS];
  logic [AW-1:0] exp_wptr = '0;
  logic [7:0]    mem[NTAPS];
  int            acc = 0;
  int            y = 0;

  function automatic int rom(input logic [AW-1:0] a);
    return 3 * int'(a) + 1;
  endfunction

  // Full-length impulse response; symmetric mode folds tap k onto NTAPS-1-k.
  function automatic int href(input int k);
    if (SYM && k >= NTAPS / 2) return rom(AW'(NTAPS - 1 - k));
    return rom(AW'(k));
  endfunction

  function automatic int ref_y(input logic [AW-1:0] nw, input logic [7:0] x);
    int s;
    s = href(0) * int'(x);
    for (int k = 1; k < NTAPS; k++) s += href(k) * hist[nw - AW'(k)];
    return s;
  endfunction

  // Behavioural datapath plus reference model; expected results queued at each accepted sample.
  always @(posedge CLK) begin
    if (RST) begin
      sb.delete();
      exp_wptr <= '0;
      for (int i = 0; i < NTAPS; i++) hist[i] <= 0;
    end else begin
      if (SMP_WE) mem[SMP_WADDR] <= SMP_ZERO ? 8'd0 : in_data;
      if (MAC_EN)
        acc <= (MAC_CLR ? 0 : acc) + rom(COEF_ADDR) *
               (int'(mem[SMP_RADDR]) + (PRE_ADD ? int'(mem[SMP_RADDR2]) : 0));
      if (ACC_LATCH) y <= acc;
      if (IN_VALID && IN_READY) begin
        sb.push_back(ref_y(exp_wptr, in_data));
        hist[exp_wptr] <= int'(in_data);
        exp_wptr <= exp_wptr + 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  // Settle after input changes; pop the scoreboard on every output handshake.
  task automatic obs();
    int e;
    #1;
    if (!RST && OUT_VALID && OUT_READY) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: Y=%0d delivered with no sample pending", y);
      end else begin
        e = sb.pop_front();
        if (y !== e) begin
          errors++;
          $display("FAIL sb_result: Y=%0d expected %0d", y, e);
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b0;
    do begin
      step();
      obs();
      t++;
    end while (!(IN_READY && !OUT_VALID) && t < 64);
    checks++;
    if (!(IN_READY && !OUT_VALID)) begin
      errors++;
      $display("FAIL %s_idle_timeout: IN_READY=%b OUT_VALID=%b after %0d cycles", tag, IN_READY, OUT_VALID, t);
    end
  endtask

  // Caller has just released RST at a negedge; IN_VALID is held high to show it is ignored.
  task automatic check_init(input string tag);
    logic [OW-1:0] e;
    for (int i = 0; i < NTAPS; i++) begin
      if (i > 0) step();
      IN_VALID = 1'b1;
      in_data  = 8'($urandom);
      obs();
      e = {1'b0, 1'b1, 1'b1, 5'b0, AW'(i), {(3 * AW){1'b0}}};
      checks++;
      if (all_outs !== e) begin
        errors++;
        $display("FAIL %s_init_%0d: outs=%h expected %h", tag, i, all_outs, e);
      end
    end
    step();
    IN_VALID = 1'b0;
    obs();
    e = {1'b1, 7'b0, {(4 * AW){1'b0}}};
    checks++;
    if (all_outs !== e) begin
      errors++;
      $display("FAIL %s_first_ready: outs=%h expected %h", tag, all_outs, e);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    obs();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outs: outs=%h expected 0", all_outs);
    end
    step();
    RST = 1'b0;
    check_init("reset");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] wseq[17];
    logic [AW-1:0] newest;
    int n = 0, t = 0, last_t = 0, bad_gap = 0, bad_w = 0, bad_r = 0;
    bit took;
    step();
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    in_data   = 8'($urandom);
    while (n < 17 && t < 17 * (LAT_OUT + 4)) begin
      obs();
      took = IN_READY;
      if (took) begin
        wseq[n] = SMP_WADDR;
        if (n > 0 && (t - last_t) != LAT_OUT) bad_gap++;
        last_t = t;
        n++;
      end
      step();
      t++;
      if (took) in_data = 8'($urandom);
    end
    IN_VALID = 1'b0;
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL b2b_count: accepted %0d samples expected 17", n);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL b2b_gap: %0d handshake intervals differ from %0d cycles", bad_gap, LAT_OUT);
    end
    for (int i = 0; i < n; i++) if (wseq[i] !== AW'(i)) bad_w++;
    checks++;
    if (bad_w != 0) begin
      errors++;
      $display("FAIL b2b_waddr: %0d write addresses off the 0..15,0 sequence", bad_w);
    end
    newest = AW'(16);
    for (int k = 0; k < STEPS; k++) begin
      if (k > 0) step();
      obs();
      if (!MAC_EN || SMP_RADDR !== newest - AW'(k)) bad_r++;
    end
    checks++;
    if (bad_r != 0) begin
      errors++;
      $display("FAIL b2b_raddr: %0d read addresses off the newest-k walk (newest=%0d)", bad_r, newest);
    end
    wait_idle("b2b");
  endtask

  task automatic test_single();
    logic [31:0] m_en = '0, m_clr = '0, m_lat = '0, m_out = '0;
    logic [31:0] x_en, x_clr, x_lat, x_out;
    logic [AW-1:0] newest, k, r2;
    int bad_a = 0;
    step();
    newest    = exp_wptr;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    in_data   = 8'($urandom);
    obs();
    checks++;
    if (!(SMP_WE && IN_READY && SMP_WADDR === newest)) begin
      errors++;
      $display("FAIL single_write: WE=%b RDY=%b WADDR=%0d expected 1 1 %0d", SMP_WE, IN_READY, SMP_WADDR, newest);
    end
    for (int c = 1; c <= LAT_OUT + 2; c++) begin
      step();
      IN_VALID = 1'b0;
      obs();
      m_en[c] = MAC_EN; m_clr[c] = MAC_CLR; m_lat[c] = ACC_LATCH; m_out[c] = OUT_VALID;
      if (MAC_EN) begin
        k  = AW'(c - 1);
        r2 = SYM ? newest + 1'b1 + k : '0;
        if (COEF_ADDR !== k || SMP_RADDR !== newest - k || SMP_RADDR2 !== r2 || PRE_ADD !== SYM) bad_a++;
      end
    end
    x_en  = ((32'd1 << STEPS) - 1) << 1;
    x_clr = 32'd1 << 1;
    x_lat = 32'd1 << (STEPS + MAC_LAT + 1);
    x_out = 32'd1 << LAT_OUT;
    checks++;
    if (m_en !== x_en) begin errors++; $display("FAIL single_mac_en: %h expected %h", m_en, x_en); end
    checks++;
    if (m_clr !== x_clr) begin errors++; $display("FAIL single_mac_clr: %h expected %h", m_clr, x_clr); end
    checks++;
    if (m_lat !== x_lat) begin errors++; $display("FAIL single_latch: %h expected %h", m_lat, x_lat); end
    checks++;
    if (m_out !== x_out) begin errors++; $display("FAIL single_out_valid: %h expected %h", m_out, x_out); end
    checks++;
    if (bad_a != 0) begin errors++; $display("FAIL single_addr: %0d MAC cycles with wrong addresses", bad_a); end
    wait_idle("single");
  endtask

  task automatic test_stall();
    int t = 0, held = 0;
    step();
    IN_VALID  = 1'b1;
    OUT_READY = 1'b0;
    in_data   = 8'($urandom);
    obs();
    do begin
      step();
      IN_VALID = 1'b0;
      obs();
      t++;
    end while (!OUT_VALID && t < 40);
    checks++;
    if (t != LAT_OUT) begin
      errors++;
      $display("FAIL stall_latency: OUT_VALID after %0d cycles expected %0d", t, LAT_OUT);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin step(); obs(); end
      if (OUT_VALID && !IN_READY && !MAC_EN) held++;
    end
    checks++;
    if (held != 5) begin
      errors++;
      $display("FAIL stall_hold: OUT_VALID held %0d of 5 stalled cycles", held);
    end
    step();
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    in_data   = 8'($urandom);
    obs();
    checks++;
    if ({OUT_VALID, IN_READY, SMP_WE} !== 3'b111) begin
      errors++;
      $display("FAIL stall_dual_hs: VALID/RDY/WE=%b expected 111", {OUT_VALID, IN_READY, SMP_WE});
    end
    step();
    IN_VALID = 1'b0;
    obs();
    checks++;
    if ({MAC_EN, MAC_CLR, IN_READY} !== 3'b110) begin
      errors++;
      $display("FAIL stall_direct_mac: EN/CLR/RDY=%b expected 110", {MAC_EN, MAC_CLR, IN_READY});
    end
    wait_idle("stall");
  endtask

  task automatic test_reset_mid_mac();
    int bad = 0;
    step();
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    in_data   = 8'($urandom);
    obs();
    for (int i = 1; i <= 8; i++) begin
      step();
      IN_VALID = 1'b0;
      obs();
    end
    checks++;
    if (!(MAC_EN && COEF_ADDR === AW'(7))) begin
      errors++;
      $display("FAIL rst_mid_position: MAC_EN=%b COEF_ADDR=%0d expected 1 7", MAC_EN, COEF_ADDR);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL rst_mid_immediate: outs=%h expected 0", all_outs);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      obs();
      if (all_outs !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_held: %0d reset cycles with nonzero outputs", bad);
    end
    step();
    RST = 1'b0;
    check_init("rst_mid");
  endtask

  task automatic test_random_traffic();
    int sent = 0, t = 0;
    while ((sent < 6 || sb.size() != 0) && t < 400) begin
      step();
      OUT_READY = 1'($urandom_range(0, 1));
      IN_VALID  = (sent < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 8'($urandom);
      obs();
      if (IN_VALID && IN_READY) sent++;
      t++;
    end
    wait_idle("random");
    checks++;
    if (sent != 6 || sb.size() != 0) begin
      errors++;
      $display("FAIL random_drain: sent=%0d pending=%0d expected 6 0", sent, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_stall();
    test_reset_mid_mac();
    test_single();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 16: number of filter taps; power of two, at least 4.
REQ-002 SHALL have parameter AW, default 4: address width, equal to log2(NTAPS).
REQ-003 SHALL have parameter MAC_LAT, default 2: multiply-accumulate pipeline depth in cycles, at least 1.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port IN_VALID  input  1  new input sample available from the upstream source.
REQ-007 SHALL have port IN_READY  output  1  sequencer accepts a sample this cycle.
REQ-008 SHALL have port SMP_WE  output  1  delay-line write enable.
REQ-009 SHALL have port SMP_ZERO  output  1  write zero instead of the input sample.
REQ-010 SHALL have port SMP_WADDR  output  AW  delay-line write address.
REQ-011 SHALL have port SMP_RADDR  output  AW  delay-line read address, port A.
REQ-012 SHALL have port SMP_RADDR2  output  AW  delay-line read address, port B (symmetric mode only).
REQ-013 SHALL have port COEF_ADDR  output  AW  coefficient ROM address.
REQ-014 SHALL have port MAC_EN  output  1  MAC accumulates this cycle.
REQ-015 SHALL have port MAC_CLR  output  1  MAC loads the product instead of adding it.
REQ-016 SHALL have port PRE_ADD  output  1  datapath adds port A and port B before multiplying.
REQ-017 SHALL have port ACC_LATCH  output  1  datapath registers the accumulator into the 32-bit Y register.
REQ-018 SHALL have port OUT_VALID  output  1  Y holds a new result.
REQ-019 SHALL have port OUT_READY  input  1  downstream consumes Y.

Function
REQ-020 SHALL implement FSM states INIT, IDLE, MAC, DRAIN, LATCH, OUT.
REQ-021 INIT SHALL last NTAPS cycles: SMP_WE=1, SMP_ZERO=1, SMP_WADDR=0..NTAPS-1 ascending; IN_READY=0; then go to IDLE.
REQ-022 IDLE SHALL drive IN_READY=1; on IN_VALID=1: SMP_WE=1, SMP_WADDR=wptr, newest is set to wptr, wptr advances (wptr+1) mod NTAPS, go to MAC.
REQ-023 MAC SHALL iterate k=0..NTAPS-1, one tap per cycle: MAC_EN=1, COEF_ADDR=k, SMP_RADDR=(newest-k) mod NTAPS; MAC_CLR=1 only at k=0.
REQ-024 DRAIN SHALL last MAC_LAT cycles with MAC_EN=0; LATCH SHALL last one cycle with ACC_LATCH=1.
REQ-025 OUT SHALL hold OUT_VALID=1 until OUT_READY=1, then go to IDLE.
REQ-026 Latency: handshake at cycle T gives ACC_LATCH at T+NTAPS+MAC_LAT+1 and OUT_VALID from T+NTAPS+MAC_LAT+2 (T+20 at default parameters).
REQ-027 IN_READY SHALL equal 1 in IDLE, or in OUT while OUT_READY=1.
REQ-028 In OUT, if OUT_READY=1 and IN_VALID=1 in the same cycle, both handshakes SHALL complete, the sample SHALL be written per REQ-022, and the FSM SHALL go directly to MAC.
REQ-029 IN_VALID SHALL be ignored outside the IN_READY=1 condition; no sample is stored or dropped silently.
REQ-030 All address arithmetic SHALL be modulo NTAPS: AW-bit wrap, no overflow flag.
REQ-031 Outputs not named active in a state SHALL be 0; address outputs not in use SHALL hold 0.

Reset
REQ-032 RST=1 SHALL immediately force state INIT with counter=0, wptr=0, newest=0, and all outputs 0, including mid-MAC or mid-OUT; no partial result is produced.
REQ-033 After RST falls, the first rising edge of CLK SHALL begin the NTAPS-cycle INIT zero-fill.

Configuration
REQ-034 With macro FIR_SYMMETRIC_EN defined, MAC SHALL last NTAPS/2 cycles (k=0..NTAPS/2-1) with PRE_ADD=1 and SMP_RADDR2=(newest-(NTAPS-1-k)) mod NTAPS; latency becomes T+NTAPS/2+MAC_LAT+2.
REQ-035 Without FIR_SYMMETRIC_EN, PRE_ADD SHALL be 0, SMP_RADDR2 SHALL be 0, and timing SHALL follow REQ-026.

Verification
REQ-036 Release RST -> SMP_WE=SMP_ZERO=1 for exactly 16 cycles with addresses 0..15; IN_READY first 1 at cycle 17.
REQ-037 Single sample at cycle T, OUT_READY=1 -> MAC_EN high T+1..T+16, MAC_CLR only at T+1, ACC_LATCH at T+19, OUT_VALID at T+20 for 1 cycle.
REQ-038 17 back-to-back samples -> SMP_WADDR sequence 0..15 then 0; on sample 17, SMP_RADDR runs 0,15,14..1.
REQ-039 OUT_READY=0 for 5 cycles, then OUT_READY=1 together with IN_VALID=1 -> OUT_VALID held 5 cycles, then MAC starts the next cycle with no IDLE cycle.
REQ-040 RST asserted at MAC step k=7 -> all outputs 0 within the same cycle, no ACC_LATCH, INIT repeats after release.
REQ-041 FIR_SYMMETRIC_EN defined, newest=3 -> 8 MAC cycles, k=0 gives SMP_RADDR=3 and SMP_RADDR2=4; OUT_VALID at T+12.
